// File: rtl/palm_identification_pkg.sv
// Shared types and constants for the palm locator: coordinate width, default
// frame size and the packed bounding-box record latched at frame close.
package palm_identification_pkg;

    localparam int COORD_W       = 8;
    localparam int SPAN_W        = COORD_W + 1;
    localparam int IMG_W_DEFAULT = 100;
    localparam int IMG_H_DEFAULT = 100;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [SPAN_W-1:0]  span_t;

    typedef struct packed {
        coord_t start_r;
        coord_t start_c;
        coord_t end_r;
        coord_t end_c;
        coord_t width;
        coord_t height;
    } palm_box_t;

    // Bottom row of the palm: row + h - 1 in 9 bits, clamped to the last frame row.
    function automatic coord_t palm_end_row(input coord_t row, input coord_t h, input coord_t last_row);
        span_t sum;
        coord_t result;
        sum = {1'b0, row} + {1'b0, h} - span_t'(9'd1);
        if (h == 8'd0) begin
            result = row;
        end else if (sum > {1'b0, last_row}) begin
            result = last_row;
        end else begin
            result = sum[COORD_W-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/palm_identification_if.sv
// Pixel stream, test override and palm box result bundled for the palm locator.
interface palm_identification_if;
    import palm_identification_pkg::*;

    logic   object_image;
    coord_t palm_height_test;
    logic   TESTING_SWITCH;
    coord_t start_of_palm_r;
    coord_t start_of_palm_c;
    coord_t end_of_palm_r;
    coord_t end_of_palm_c;
    coord_t palm_width;
    coord_t palm_height;

    modport master (
        output object_image, palm_height_test, TESTING_SWITCH,
        input  start_of_palm_r, start_of_palm_c, end_of_palm_r,
        input  end_of_palm_c, palm_width, palm_height
    );

    modport slave (
        input  object_image, palm_height_test, TESTING_SWITCH,
        output start_of_palm_r, start_of_palm_c, end_of_palm_r,
        output end_of_palm_c, palm_width, palm_height
    );
endinterface

// File: rtl/palm_identification.sv
// Streaming palm locator: scans a raster-order binary mask, tracks the widest
// object row and latches a palm bounding box anchored there at each frame end.
module palm_identification
    import palm_identification_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEFAULT,
    parameter int IMG_H = IMG_H_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    palm_identification_if.slave  pif
);

    localparam coord_t LAST_COL = coord_t'(IMG_W - 1);
    localparam coord_t LAST_ROW = coord_t'(IMG_H - 1);

    coord_t    col_r;
    coord_t    row_r;
    logic      row_hit_r;
    coord_t    first_c_r;
    coord_t    last_c_r;
    span_t     best_span_r;
    coord_t    best_row_r;
    coord_t    best_first_c_r;
    coord_t    best_last_c_r;
    palm_box_t box_r;

    logic      last_col_s;
    logic      last_row_s;
    logic      frame_end_s;
    logic      cur_hit_s;
    coord_t    cur_first_s;
    coord_t    cur_last_s;
    span_t     span_s;
    logic      row_wins_s;
    span_t     nb_span_s;
    coord_t    nb_row_s;
    coord_t    nb_first_c_s;
    coord_t    nb_last_c_s;
    coord_t    h_s;
    palm_box_t next_box_s;

    // Merge the current pixel into the row/frame state so last-column and last-pixel closes see it.
    always_comb begin
        last_col_s  = (col_r == LAST_COL);
        last_row_s  = (row_r == LAST_ROW);
        frame_end_s = last_col_s && last_row_s;
        cur_hit_s   = row_hit_r || pif.object_image;

        if (row_hit_r) begin
            cur_first_s = first_c_r;
        end else begin
            cur_first_s = col_r;
        end

        if (pif.object_image) begin
            cur_last_s = col_r;
        end else begin
            cur_last_s = last_c_r;
        end

        span_s     = {1'b0, cur_last_s} - {1'b0, cur_first_s} + span_t'(9'd1);
        // Strictly greater keeps the upper row on ties.
        row_wins_s = last_col_s && cur_hit_s && (span_s > best_span_r);

        if (row_wins_s) begin
            nb_span_s    = span_s;
            nb_row_s     = row_r;
            nb_first_c_s = cur_first_s;
            nb_last_c_s  = cur_last_s;
        end else begin
            nb_span_s    = best_span_r;
            nb_row_s     = best_row_r;
            nb_first_c_s = best_first_c_r;
            nb_last_c_s  = best_last_c_r;
        end

        if (pif.TESTING_SWITCH) begin
            h_s = pif.palm_height_test;
        end else begin
            h_s = nb_span_s[COORD_W-1:0];
        end

        if (nb_span_s == span_t'(9'd0)) begin
            next_box_s = '0;
        end else begin
            next_box_s.start_r = nb_row_s;
            next_box_s.start_c = nb_first_c_s;
            next_box_s.end_r   = palm_end_row(nb_row_s, h_s, LAST_ROW);
            next_box_s.end_c   = nb_last_c_s;
            next_box_s.width   = nb_span_s[COORD_W-1:0];
            next_box_s.height  = h_s;
        end
    end

    // Raster position counters; row wrap marks the end of the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_r <= 8'd0;
            row_r <= 8'd0;
        end else if (last_col_s) begin
            col_r <= 8'd0;
            if (last_row_s) begin
                row_r <= 8'd0;
            end else begin
                row_r <= row_r + 8'd1;
            end
        end else begin
            col_r <= col_r + 8'd1;
        end
    end

    // Per-row object extent, cleared when the row closes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_hit_r <= 1'b0;
            first_c_r <= 8'd0;
            last_c_r  <= 8'd0;
        end else if (last_col_s) begin
            row_hit_r <= 1'b0;
            first_c_r <= 8'd0;
            last_c_r  <= 8'd0;
        end else begin
            row_hit_r <= cur_hit_s;
            first_c_r <= cur_first_s;
            last_c_r  <= cur_last_s;
        end
    end

    // Widest row seen so far in this frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_span_r    <= 9'd0;
            best_row_r     <= 8'd0;
            best_first_c_r <= 8'd0;
            best_last_c_r  <= 8'd0;
        end else if (frame_end_s) begin
            best_span_r    <= 9'd0;
            best_row_r     <= 8'd0;
            best_first_c_r <= 8'd0;
            best_last_c_r  <= 8'd0;
        end else if (row_wins_s) begin
            best_span_r    <= span_s;
            best_row_r     <= row_r;
            best_first_c_r <= cur_first_s;
            best_last_c_r  <= cur_last_s;
        end else begin
            best_span_r    <= best_span_r;
            best_row_r     <= best_row_r;
            best_first_c_r <= best_first_c_r;
            best_last_c_r  <= best_last_c_r;
        end
    end

    // Result box, updated only at frame close and held in between.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            box_r <= '0;
        end else if (frame_end_s) begin
            box_r <= next_box_s;
        end else begin
            box_r <= box_r;
        end
    end

    assign pif.start_of_palm_r = box_r.start_r;
    assign pif.start_of_palm_c = box_r.start_c;
    assign pif.end_of_palm_r   = box_r.end_r;
    assign pif.end_of_palm_c   = box_r.end_c;
    assign pif.palm_width      = box_r.width;
    assign pif.palm_height     = box_r.height;

endmodule

// File: tb/tb_palm_identification.sv
// Directed bench for the palm locator on an 8x8 frame; pixels change on the
// falling edge and results are sampled on the falling edge after the last pixel.
module tb_palm_identification;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    palm_identification_if pif ();

    palm_identification #(.IMG_W(8), .IMG_H(8)) dut (
        .clk (clk),
        .rst (rst),
        .pif (pif)
    );

    function automatic logic [47:0] box(input int sr, input int sc, input int er,
                                        input int ec, input int w, input int h);
        return {sr[7:0], sc[7:0], er[7:0], ec[7:0], w[7:0], h[7:0]};
    endfunction

    function automatic logic [47:0] obs();
        return {pif.start_of_palm_r, pif.start_of_palm_c, pif.end_of_palm_r,
                pif.end_of_palm_c, pif.palm_width, pif.palm_height};
    endfunction

    // Bit index is row*8 + col.
    function automatic logic [63:0] rect(input int r0, input int r1, input int c0, input int c1);
        logic [63:0] m;
        m = 64'd0;
        for (int r = r0; r <= r1; r++)
            for (int c = c0; c <= c1; c++)
                m[r*8 + c] = 1'b1;
        return m;
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic drive_pixel(input logic b);
        pif.object_image = b;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [63:0] m);
        for (int i = 0; i < 64; i++) drive_pixel(m[i]);
    endtask

    task automatic test_reset();
        logic [47:0] exp;
        rst = 1'b1;
        pif.object_image = 1'b0;
        pif.palm_height_test = 8'd0;
        pif.TESTING_SWITCH = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== 48'd0) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", obs(), 48'd0);
        end
        rst = 1'b0;
        send_frame(rect(2, 5, 1, 4));
        exp = box(2, 1, 5, 4, 4, 4);
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL rectangle: got %h want %h", obs(), exp);
        end
        // Part of a frame, then an asynchronous reset between clock edges.
        for (int i = 0; i < 20; i++) drive_pixel(1'b1);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs() !== 48'd0) begin
            errors++;
            $display("FAIL mid_reset_clear: got %h want %h", obs(), 48'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        send_frame(rect(1, 3, 2, 6));
        exp = box(1, 2, 5, 6, 5, 5);
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL after_reset_frame: got %h want %h", obs(), exp);
        end
    endtask

    task automatic test_finger_palm();
        logic [47:0] exp;
        send_frame(rect(1, 1, 3, 3) | rect(3, 6, 1, 6));
        exp = box(3, 1, 7, 6, 6, 6);
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL finger_palm: got %h want %h", obs(), exp);
        end
    endtask

    task automatic test_override();
        logic [63:0] m;
        logic [47:0] exp;
        m = rect(1, 1, 3, 3) | rect(3, 6, 1, 6);
        // Switch raised only for the closing pixel.
        pif.TESTING_SWITCH = 1'b0;
        pif.palm_height_test = 8'd2;
        for (int i = 0; i < 63; i++) drive_pixel(m[i]);
        pif.TESTING_SWITCH = 1'b1;
        drive_pixel(m[63]);
        exp = box(3, 1, 4, 6, 6, 2);
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL override_h2: got %h want %h", obs(), exp);
        end
        // Switch high during the frame but low at close: derived height.
        for (int i = 0; i < 63; i++) drive_pixel(m[i]);
        pif.TESTING_SWITCH = 1'b0;
        drive_pixel(m[63]);
        exp = box(3, 1, 7, 6, 6, 6);
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL override_sampled_at_close: got %h want %h", obs(), exp);
        end
        // Zero override height anchors the bottom at the top row.
        pif.TESTING_SWITCH = 1'b1;
        pif.palm_height_test = 8'd0;
        send_frame(m);
        exp = box(3, 1, 3, 6, 6, 0);
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL override_h0: got %h want %h", obs(), exp);
        end
        // Large override clamps at the last row.
        pif.palm_height_test = 8'd255;
        send_frame(m);
        exp = box(3, 1, 7, 6, 6, 255);
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL override_h255: got %h want %h", obs(), exp);
        end
        pif.TESTING_SWITCH = 1'b0;
        pif.palm_height_test = 8'd0;
    endtask

    task automatic test_empty_and_corner();
        logic [63:0] m;
        logic [47:0] exp;
        send_frame(64'd0);
        checks++;
        if (obs() !== 48'd0) begin
            errors++;
            $display("FAIL empty_frame: got %h want %h", obs(), 48'd0);
        end
        m = 64'd0;
        m[63] = 1'b1;
        send_frame(m);
        exp = box(7, 7, 7, 7, 1, 1);
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL corner_pixel: got %h want %h", obs(), exp);
        end
    endtask

    task automatic test_full_width();
        logic [47:0] exp;
        // Row 4 is full width; rows 5..7 tie and must not replace it.
        send_frame(rect(4, 7, 0, 7) | rect(2, 2, 3, 5));
        exp = box(4, 0, 7, 7, 8, 8);
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL full_width: got %h want %h", obs(), exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] m;
        logic [47:0] exp1;
        logic [47:0] exp2;
        logic [47:0] bad_val;
        int          bad_idx;
        send_frame(rect(2, 5, 1, 4));
        exp1 = box(2, 1, 5, 4, 4, 4);
        checks++;
        if (obs() !== exp1) begin
            errors++;
            $display("FAIL b2b_frame1: got %h want %h", obs(), exp1);
        end
        m = rect(1, 1, 3, 3) | rect(3, 6, 1, 6);
        bad_idx = -1;
        bad_val = 48'd0;
        for (int i = 0; i < 64; i++) begin
            if (bad_idx < 0 && obs() !== exp1) begin
                bad_idx = i;
                bad_val = obs();
            end
            drive_pixel(m[i]);
        end
        checks++;
        if (bad_idx >= 0) begin
            errors++;
            $display("FAIL b2b_hold: at pixel %0d got %h want %h", bad_idx, bad_val, exp1);
        end
        exp2 = box(3, 1, 7, 6, 6, 6);
        checks++;
        if (obs() !== exp2) begin
            errors++;
            $display("FAIL b2b_frame2: got %h want %h", obs(), exp2);
        end
    endtask

    initial begin
        test_reset();
        test_finger_palm();
        test_override();
        test_empty_and_corner();
        test_full_width();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
